ir_tx: RTL and testbench
========================

IR_TX -- requirements
Module: ir_tx

Interface
REQ-001 Parameter CLK_PER_US, default 50: number of clk cycles per 1 us timing tick (50 MHz clk).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  frame request, level-sampled on clk only while idle.
REQ-005 i_data  input  32  NEC frame {custom, ~custom, data, ~data}; bit 31 is transmitted first.
REQ-006 o_ir_txb  output  1  inverted baseband IR envelope: 0 = mark (burst), 1 = space; no carrier.
REQ-007 o_busy  output  1  high while a frame, repeat code or inter-frame gap is in progress.
REQ-008 o_done  output  1  one-clk pulse at the end of the stop mark of each frame or repeat code.

Function
REQ-009 One clock domain: a prescaler counts 0..CLK_PER_US-1 to make a 1 us tick, and a 17-bit us counter times each segment.
REQ-010 The prescaler and us counter shall clear at every segment start, so each segment lasts exactly N*CLK_PER_US clk cycles.
REQ-011 The FSM shall have these states: IDLE, LEAD_M, LEAD_S, BIT_M, BIT_S, STOP_M, GAP, and REP_S when the repeat feature is compiled in.
REQ-012 IDLE with i_start=1 at a clk edge: i_data shall be latched into a 32-bit shift register, and on the following clk o_busy=1, o_ir_txb=0 and the state is LEAD_M.
REQ-013 LEAD_M shall last 9000 us of mark, then LEAD_S shall last 4500 us of space.
REQ-014 Each bit shall be a BIT_M of 560 us mark, then a BIT_S of 560 us space for a 0 or 1690 us space for a 1; the MSB is sent first.
REQ-015 A 6-bit bit counter shall step 0..31; after BIT_S of bit 31 the state shall be STOP_M (560 us mark).
REQ-016 At the end of STOP_M, o_done=1 for exactly one clk, o_ir_txb returns to 1, and the state becomes GAP.
REQ-017 GAP shall hold space until 108000 us have elapsed since the first mark clk of the frame; o_busy stays 1 through GAP.
REQ-018 At the end of GAP the state shall be IDLE and o_busy=0 on that clk, unless REQ-025 applies.
REQ-019 i_start and i_data changes while o_busy=1 shall be ignored, and the latched frame shall not be corrupted.
REQ-020 If i_start is held high continuously, one full frame shall start every 108000 us, with one idle clk between frames.
REQ-021 o_ir_txb shall be driven from a register (glitch-free); o_busy and o_done are also registered.

Reset
REQ-022 rst_n=0 shall immediately force state=IDLE, o_ir_txb=1, o_busy=0, o_done=0, and shall clear all counters and the shift register.
REQ-023 Reset asserted mid-frame shall abort the frame with no o_done; after release the block waits in IDLE for a new i_start.

Configuration
REQ-024 Macro IR_TX_REPEAT_EN selects NEC repeat-code support; when it is undefined, REP_S and the repeat logic shall not exist and REQ-020 applies.
REQ-025 With IR_TX_REPEAT_EN defined, i_start=1 at the end of GAP shall send a repeat code: LEAD_M 9000 us, REP_S 2250 us space, STOP_M 560 us, o_done pulse, then GAP to 108000 us from the repeat's first mark.
REQ-026 With IR_TX_REPEAT_EN defined, repeats shall continue while i_start stays high; i_start=0 at the end of GAP goes to IDLE, and the next request sends a full frame.

Verification
REQ-027 Reset, then i_start pulse with i_data=32'h00FF_40BF: o_ir_txb low for exactly 450000 clk, high 225000 clk, then 32 bits MSB first, o_done once, o_busy low at 5400000 clk after the first mark.
REQ-028 i_data=32'h0000_0000 vs 32'hFFFF_FFFF: each bit space measures 28000 clk vs 84500 clk respectively; the stop mark is 28000 clk.
REQ-029 Loopback o_ir_txb -> top module i_ir_rxb with i_data=32'h12ED_34CB: the receiver data word equals 32'h12ED_34CB; the display shows ED34CB.
REQ-030 rst_n pulsed low during bit 10: o_ir_txb=1 and o_busy=0 within the same cycle; no o_done; a new frame after release is bit-exact.
REQ-031 i_start toggled and i_data changed during BIT_S: the transmitted waveform is unchanged and no second frame starts before GAP ends.
REQ-032 IR_TX_REPEAT_EN defined, i_start held for 250 ms: one full frame, then two repeat codes (9000/2250/560 us), each starting 108000 us apart; with the macro undefined, three full frames.

Source files
------------

// File: rtl/ir_tx.sv
// NEC infrared transmitter: 32-bit frame to an inverted baseband envelope (0 = mark), no carrier.
// Define IR_TX_REPEAT_EN to send NEC repeat codes while i_start stays high after a frame.
module ir_tx #(
  parameter int CLK_PER_US = 50,
  parameter int LEAD_M_US  = 9000,
  parameter int LEAD_S_US  = 4500,
  parameter int BIT_M_US   = 560,
  parameter int BIT0_S_US  = 560,
  parameter int BIT1_S_US  = 1690,
  parameter int STOP_M_US  = 560,
  parameter int FRAME_US   = 108000
`ifdef IR_TX_REPEAT_EN
  ,
  parameter int REP_S_US   = 2250
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data,
  output logic        o_ir_txb,
  output logic        o_busy,
  output logic        o_done
);

  localparam int               PRE_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEAD_M = 3'd1;
  localparam logic [2:0] LEAD_S = 3'd2;
  localparam logic [2:0] BIT_M  = 3'd3;
  localparam logic [2:0] BIT_S  = 3'd4;
  localparam logic [2:0] STOP_M = 3'd5;
  localparam logic [2:0] GAP    = 3'd6;
`ifdef IR_TX_REPEAT_EN
  localparam logic [2:0] REP_S  = 3'd7;
`endif

  logic [2:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [16:0]      us_q, us_d;
  logic [16:0]      frame_us_q, frame_us_d;
  logic [5:0]       bit_q, bit_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             ir_q, ir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef IR_TX_REPEAT_EN
  logic             rep_q, rep_d;
`endif

  logic             tick;
  logic             seg_end;
  logic             frame_end;
  logic [16:0]      seg_last;

  // Last us-counter value of a segment lasting 'us' microseconds.
  function automatic logic [16:0] us_last(input int us);
    return 17'(us - 1);
  endfunction

  assign tick      = (pre_q == PRE_LAST);
  assign seg_end   = tick && (us_q == seg_last);
  assign frame_end = tick && (frame_us_q == us_last(FRAME_US));

  always_comb begin
    seg_last = us_last(FRAME_US);
    case (state_q)
      LEAD_M:  seg_last = us_last(LEAD_M_US);
      LEAD_S:  seg_last = us_last(LEAD_S_US);
      BIT_M:   seg_last = us_last(BIT_M_US);
      BIT_S:   seg_last = shreg_q[31] ? us_last(BIT1_S_US) : us_last(BIT0_S_US);
      STOP_M:  seg_last = us_last(STOP_M_US);
`ifdef IR_TX_REPEAT_EN
      REP_S:   seg_last = us_last(REP_S_US);
`endif
      default: seg_last = us_last(FRAME_US);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = tick ? '0 : pre_q + 1'b1;
    us_d       = tick ? us_q + 17'd1 : us_q;
    frame_us_d = tick ? frame_us_q + 17'd1 : frame_us_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
`ifdef IR_TX_REPEAT_EN
    rep_d      = rep_q;
`endif
    // Segment boundaries coincide with a prescaler wrap, so only the us counter needs clearing.
    if (seg_end) begin
      us_d = '0;
    end

    case (state_q)
      IDLE: begin
        pre_d      = '0;
        us_d       = '0;
        frame_us_d = '0;
        if (i_start) begin
          shreg_d = i_data;
          bit_d   = '0;
          state_d = LEAD_M;
`ifdef IR_TX_REPEAT_EN
          rep_d   = 1'b0;
`endif
        end
      end
      LEAD_M: begin
        if (seg_end) begin
`ifdef IR_TX_REPEAT_EN
          state_d = rep_q ? REP_S : LEAD_S;
`else
          state_d = LEAD_S;
`endif
        end
      end
      LEAD_S: begin
        if (seg_end) begin
          state_d = BIT_M;
        end
      end
      BIT_M: begin
        if (seg_end) begin
          state_d = BIT_S;
        end
      end
      BIT_S: begin
        if (seg_end) begin
          if (bit_q == 6'd31) begin
            state_d = STOP_M;
          end else begin
            bit_d   = bit_q + 6'd1;
            shreg_d = {shreg_q[30:0], 1'b0};
            state_d = BIT_M;
          end
        end
      end
`ifdef IR_TX_REPEAT_EN
      REP_S: begin
        if (seg_end) begin
          state_d = STOP_M;
        end
      end
`endif
      STOP_M: begin
        if (seg_end) begin
          state_d = GAP;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        us_d = '0;
        // Frame period is measured from the first mark clk, independent of frame content.
        if (frame_end) begin
          frame_us_d = '0;
          state_d    = IDLE;
`ifdef IR_TX_REPEAT_EN
          if (i_start) begin
            state_d = LEAD_M;
            rep_d   = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    ir_d   = !((state_d == LEAD_M) || (state_d == BIT_M) || (state_d == STOP_M));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      us_q       <= '0;
      frame_us_q <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      ir_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IR_TX_REPEAT_EN
      rep_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      us_q       <= us_d;
      frame_us_q <= frame_us_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      ir_q       <= ir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef IR_TX_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign o_ir_txb = ir_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_ir_tx.sv
// Scoreboard bench for ir_tx with scaled-down timing; expected envelope runs are queued per code.
module tb_ir_tx;

  localparam int C  = 2;
  localparam int LM = 90;
  localparam int LS = 45;
  localparam int BM = 6;
  localparam int B0 = 6;
  localparam int B1 = 17;
  localparam int ST = 6;
  localparam int RP = 23;
  localparam int FR = 1080;
  localparam int BIG = 1 << 30;

  typedef struct packed {
    logic lvl;
    int   lo;
    int   hi;
  } seg_t;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_data;
  logic        o_ir_txb;
  logic        o_busy;
  logic        o_done;

  seg_t seg_q[$];
  int   busy_q[$];
  int   n_chk;
  int   n_fail;
  int   exp_done;
  int   done_cnt;

  ir_tx #(
    .CLK_PER_US(C), .LEAD_M_US(LM), .LEAD_S_US(LS), .BIT_M_US(BM),
    .BIT0_S_US(B0), .BIT1_S_US(B1), .STOP_M_US(ST), .FRAME_US(FR)
`ifdef IR_TX_REPEAT_EN
    , .REP_S_US(RP)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_data   (i_data),
    .o_ir_txb (o_ir_txb),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic push_seg(input logic l, input int lo, input int hi);
    seg_t s;
    s.lvl = l;
    s.lo  = lo;
    s.hi  = hi;
    seg_q.push_back(s);
  endtask

  // Envelope of one code from the protocol rules; next: 0 = idle follows, 1 = full frame follows, 2 = repeat follows.
  task automatic push_code(input logic [31:0] d, input bit rep, input int next);
    int a;
    int base;
    a = 0;
    push_seg(1'b0, LM * C, LM * C);
    a += LM * C;
    if (rep) begin
      push_seg(1'b1, RP * C, RP * C);
      a += RP * C;
    end else begin
      push_seg(1'b1, LS * C, LS * C);
      a += LS * C;
      for (int i = 31; i >= 0; i--) begin
        push_seg(1'b0, BM * C, BM * C);
        push_seg(1'b1, (d[i] ? B1 : B0) * C, (d[i] ? B1 : B0) * C);
        a += (BM + (d[i] ? B1 : B0)) * C;
      end
    end
    push_seg(1'b0, ST * C, ST * C);
    a += ST * C;
    base = FR * C - a;
    if (next == 0)      push_seg(1'b1, base + 1, BIG);
    else if (next == 1) push_seg(1'b1, base + 1, base + 1);
    else                push_seg(1'b1, base, base);
    exp_done++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] d);
    i_data  = d;
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    i_data  = $urandom;
  endtask

  task automatic send_frame(input logic [31:0] d);
    push_code(d, 1'b0, 0);
    busy_q.push_back(FR * C);
    pulse_start(d);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 4 * FR * C) begin
      cyc(1);
      n++;
    end
    chk("busy_release", o_busy, 0, 0);
    cyc(5);
  endtask

  // Cycles from the first lead-mark clk to the start of bit k's mark.
  function automatic int bit_offset(input logic [31:0] d, input int k);
    int off;
    off = (LM + LS) * C;
    for (int i = 0; i < k; i++) off += (BM + (d[31 - i] ? B1 : B0)) * C;
    return off;
  endfunction

  // Monitor: measures every envelope run and busy window and pops the matching expectation.
  initial begin
    logic prev_ir;
    logic prev_done;
    int   run;
    int   busy_run;
    seg_t e;
    int   eb;
    prev_ir   = 1'b1;
    prev_done = 1'b0;
    run       = 0;
    busy_run  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ir   = 1'b1;
        prev_done = 1'b0;
        run       = 0;
        busy_run  = 0;
      end else begin
        if (o_ir_txb !== prev_ir) begin
          chk("edge_expected", seg_q.size(), 1, BIG);
          if (seg_q.size() > 0) begin
            e = seg_q.pop_front();
            chk("seg_level", prev_ir, e.lvl, e.lvl);
            chk("seg_len", run, e.lo, e.hi);
          end
          run = 1;
        end else begin
          run++;
        end
        if (o_busy) begin
          busy_run++;
        end else if (busy_run > 0) begin
          chk("busy_expected", busy_q.size(), 1, BIG);
          if (busy_q.size() > 0) begin
            eb = busy_q.pop_front();
            chk("busy_len", busy_run, eb, eb);
          end
          busy_run = 0;
        end
        if (o_done) begin
          chk("done_single", prev_done, 0, 0);
          chk("done_at_stop_end", {prev_ir, o_ir_txb}, 1, 1);
          done_cnt++;
        end
        prev_ir   = o_ir_txb;
        prev_done = o_done;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    n_chk    = 0;
    n_fail   = 0;
    exp_done = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_data   = '0;
    push_seg(1'b1, 1, BIG);
    cyc(3);
    chk("rst_ir_txb", o_ir_txb, 1, 1);
    chk("rst_busy", o_busy, 0, 0);
    chk("rst_done", o_done, 0, 0);
    rst_n = 1'b1;
    cyc(3);

    send_frame(32'h00FF_40BF);
    wait_idle();
    send_frame(32'h0000_0000);
    wait_idle();
    send_frame(32'hFFFF_FFFF);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      send_frame($urandom);
      wait_idle();
    end

    // Abort during bit 10, then a clean frame.
    d = $urandom;
    send_frame(d);
    cyc(bit_offset(d, 10) + 2);
    seg_q.delete();
    busy_q.delete();
    exp_done--;
    rst_n = 1'b0;
    #1;
    chk("abort_ir_txb", o_ir_txb, 1, 1);
    chk("abort_busy", o_busy, 0, 0);
    push_seg(1'b1, 1, BIG);
    cyc(3);
    rst_n = 1'b1;
    cyc(4);
    chk("abort_stays_idle", o_busy, 0, 0);
    send_frame(32'h12ED_34CB);
    wait_idle();

    // Input churn while a frame is on air.
    d = $urandom;
    send_frame(d);
    cyc(bit_offset(d, 0) + BM * C + 2);
    for (int i = 0; i < 40; i++) begin
      i_start = 1'($urandom_range(0, 1));
      i_data  = $urandom;
      cyc(1);
    end
    i_start = 1'b0;
    wait_idle();

    // Held request for about 2.5 frame periods.
    d = $urandom;
`ifdef IR_TX_REPEAT_EN
    push_code(d, 1'b0, 2);
    push_code(d, 1'b1, 2);
    push_code(d, 1'b1, 0);
    busy_q.push_back(3 * FR * C);
`else
    push_code(d, 1'b0, 1);
    push_code(d, 1'b0, 1);
    push_code(d, 1'b0, 0);
    busy_q.push_back(FR * C);
    busy_q.push_back(FR * C);
    busy_q.push_back(FR * C);
`endif
    i_data  = d;
    i_start = 1'b1;
    cyc(2 * (FR * C + 1) + 1000);
    i_start = 1'b0;
    wait_idle();
    cyc(10);

    chk("done_count", done_cnt, exp_done, exp_done);
    chk("seg_leftover", seg_q.size(), 1, 1);
    chk("busy_leftover", busy_q.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
